// File: rtl/alu_result_unit.sv
// alu_result_unit: two-stage adder back end with carry/borrow recovery,
// Z/C/V flag commit and a carry-hazard interlock for ops that consume cin.
module alu_result_unit #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         c_in,
    input  logic [1:0]   s,
    input  logic         flag_we,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         z_flag,
    output logic         c_flag,
    output logic         v_flag,
    output logic         cin_o,
    output logic         busy
);

    localparam int unsigned SW = W + 1;

    // stage 1 holding registers
    logic         v1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         c1;
    logic         sub1;
    logic         we1;

    // stage 2 holding registers
    logic         v2;
    logic [W-1:0] r2;
    logic         co2;
    logic         z2;
    logic         ov2;
    logic         we2;

    logic          s2_ready;
    logic          s1_ready;
    logic          hazard;
    logic          in_hs;
    logic          advance;
    logic          out_hs;
    logic [SW-1:0] sum;
    logic [W-1:0]  r_next;
    logic          co_next;
    logic          z_next;
    logic          ov_next;

    // handshake and ready chain; a cin-consuming op waits for pending flag writes
    assign s2_ready = ~v2 | out_ready;
    assign s1_ready = ~v1 | s2_ready;
    assign hazard   = s[0] & ((v1 & we1) | (v2 & we2));
    assign in_ready = s1_ready & ~hazard;
    assign in_hs    = in_valid & in_ready;
    assign advance  = v1 & s2_ready;
    assign out_hs   = v2 & out_ready;

    // sum and flag derivation from stage-1 operands; sub ops report borrow
    always_comb begin
        sum     = {1'b0, a1} + {1'b0, b1} + SW'(c1);
        r_next  = sum[W-1:0];
        co_next = sum[W] ^ sub1;
        z_next  = (r_next == '0);
        ov_next = (a1[W-1] == b1[W-1]) & (r_next[W-1] != a1[W-1]);
    end

    // stage 1 register: capture operands on input handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            c1   <= 1'b0;
            sub1 <= 1'b0;
            we1  <= 1'b0;
        end else begin
            if (in_hs) begin
                v1   <= 1'b1;
                a1   <= opa;
                b1   <= opb;
                c1   <= c_in;
                sub1 <= s[1];
                we1  <= flag_we;
            end else if (advance) begin
                v1 <= 1'b0;
            end
        end
    end

    // stage 2 register: result and candidate flags, held under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            r2  <= '0;
            co2 <= 1'b0;
            z2  <= 1'b0;
            ov2 <= 1'b0;
            we2 <= 1'b0;
        end else begin
            if (advance) begin
                v2  <= 1'b1;
                r2  <= r_next;
                co2 <= co_next;
                z2  <= z_next;
                ov2 <= ov_next;
                we2 <= we1;
            end else if (out_hs) begin
                v2 <= 1'b0;
            end
        end
    end

    // committed flags load when a flag-writing op leaves the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            v_flag <= 1'b0;
        end else if (out_hs && we2) begin
            z_flag <= z2;
            c_flag <= co2;
            v_flag <= ov2;
        end
    end

    assign result    = r2;
    assign out_valid = v2;
    assign cin_o     = c_flag;
    assign busy      = v1 | v2;

endmodule

// File: tb/tb_alu_result_unit.sv
// Self-checking bench for alu_result_unit: directed table, hazard,
// backpressure and reset sequences, plus randomized traffic against a model.
module tb_alu_result_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       c_in;
    logic [1:0] s;
    logic       flag_we;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;
    logic       cin_o;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int out_count = 0;

    typedef struct {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       v;
        logic       we;
    } item_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [1:0] sel;
        logic [7:0] r;
        logic       z;
        logic       cf;
        logic       v;
    } vec_t;

    item_t q[$];
    logic  mz = 1'b0;
    logic  mc = 1'b0;
    logic  mv = 1'b0;
    item_t pop_it;
    bit    hz;

    alu_result_unit #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .c_in(c_in), .s(s), .flag_we(flag_we),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag),
        .cin_o(cin_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: plain integer arithmetic, signed range test for overflow
    function automatic item_t ref_op(input logic [7:0] a, input logic [7:0] b,
                                     input logic c, input logic [1:0] sel, input logic we);
        item_t it;
        int sum, sa, sb, ss;
        sum   = int'(a) + int'(b) + int'(c);
        it.r  = 8'(sum % 256);
        it.z  = ((sum % 256) == 0);
        it.c  = (sum >= 256) ^ sel[1];
        sa    = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb    = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        ss    = sa + sb + int'(c);
        it.v  = (ss > 127) || (ss < -128);
        it.we = we;
        return it;
    endfunction

    // scoreboard: track in-flight ops, expected flags and ready behaviour
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mz = 1'b0; mc = 1'b0; mv = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("z_flag", 32'(z_flag), 32'(mz));
            chk("c_flag", 32'(c_flag), 32'(mc));
            chk("v_flag", 32'(v_flag), 32'(mv));
            chk("cin_o", 32'(cin_o), 32'(mc));
            hz = 1'b0;
            foreach (q[i]) if (q[i].we) hz = 1'b1;
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2 || out_ready) && !(s[0] && hz)));
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
                else chk("result", 32'(result), 32'(q[0].r));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                pop_it = q.pop_front();
                out_count++;
                if (pop_it.we) begin
                    mz = pop_it.z; mc = pop_it.c; mv = pop_it.v;
                end
            end
            if (in_valid && in_ready) q.push_back(ref_op(opa, opb, c_in, s, flag_we));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present an op and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [1:0] sel, input logic we);
        bit ok;
        ok = 1'b0;
        opa = a; opb = b; c_in = c; s = sel; flag_we = we; in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1 at %0t", $time);
        end
    endtask

    vec_t tbl[8];
    int   oc0;

    initial begin
        tbl[0] = '{8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h05, 8'hFA, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h03, 8'hFA, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 2'b01, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h10, 8'hDF, 1'b1, 2'b11, 8'hF0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h7F, 8'h7F, 1'b1, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; opa = '0; opb = '0; c_in = 1'b0;
        s = 2'b00; flag_we = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({z_flag, c_flag, v_flag}), 32'd0);
        chk("rst_cin_o", 32'(cin_o), 32'd0);
        rst = 1'b0;
        tick();

        // directed vectors with latency and committed-flag checks
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sel, 1'b1);
            chk($sformatf("t%0d_lat_early", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("t%0d_result", i), 32'(result), 32'(tbl[i].r));
            tick();
            chk($sformatf("t%0d_zcv", i), 32'({z_flag, c_flag, v_flag}),
                32'({tbl[i].z, tbl[i].cf, tbl[i].v}));
            chk($sformatf("t%0d_cin_o", i), 32'(cin_o), 32'(tbl[i].cf));
        end

        // backpressure: three we=0 ops, output stalled four cycles
        oc0 = out_count;
        fork
            begin
                send(8'h10, 8'h01, 1'b0, 2'b00, 1'b0);
                send(8'h20, 8'h02, 1'b0, 2'b00, 1'b0);
                opa = 8'h30; opb = 8'h03; c_in = 1'b0; s = 2'b00; flag_we = 1'b0; in_valid = 1'b1;
                @(negedge clk);
                chk("bp_full_in_ready", 32'(in_ready), 32'd0);
                chk("bp_hold_result", 32'(result), 32'h11);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                tick();
                send(8'h30, 8'h03, 1'b0, 2'b00, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("bp_out_count", 32'(out_count - oc0), 32'd3);
        chk("bp_flags_kept", 32'({z_flag, c_flag, v_flag}), 32'b111);
        chk("bp_idle", 32'(busy), 32'd0);

        // carry hazard: flag-writing add followed by add-with-carry
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 1'b0, 2'b00, 1'b1);
        opa = 8'h00; opb = 8'h00; c_in = 1'b1; s = 2'b01; flag_we = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hz_blocked", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hz_blocked_hs_cycle", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("hz_released", 32'(in_ready), 32'd1);
        chk("hz_cin_o", 32'(cin_o), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hz_result_valid", 32'(out_valid), 32'd1);
        chk("hz_result", 32'(result), 32'h01);
        repeat (2) tick();

        // randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            s         = 2'($urandom_range(0, 3));
            flag_we   = 1'($urandom_range(0, 1));
            opa       = 8'($urandom);
            opb       = 8'($urandom);
            c_in      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        // reset with two ops in flight
        send(8'h80, 8'h80, 1'b0, 2'b00, 1'b1);
        repeat (2) tick();
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 2'b00, 1'b1);
        send(8'h03, 8'h04, 1'b0, 2'b00, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_flags", 32'({z_flag, c_flag, v_flag}), 32'd0);
        chk("mid_rst_cin_o", 32'(cin_o), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_unit.md
Name: alu_result_unit

Overview:
- Back end of the Gumnut adder path, consuming the adjusted operands and carry produced by the operand-extension stage.
- Computes the sum through a 2-stage valid/ready pipeline and recovers true carry/borrow for subtract ops.
- Derives Z/C/V flags and holds the committed flags.
- Feeds the committed carry back as the cin for the next add-with-carry or subtract-with-borrow.

Parameters:
- W, 8, data width of operands and result; carry, zero and overflow are derived at this width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  unit accepts the operand set this cycle
- opa  input  W  operand A, already adjusted upstream
- opb  input  W  operand B, already adjusted upstream (B or ~B)
- c_in  input  1  adder carry-in, already adjusted upstream
- s  input  2  op select: 00 add, 01 add+cin, 10 sub, 11 sub-cin
- flag_we  input  1  commit this op's flags
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- result  output  W  sum[W-1:0]
- z_flag  output  1  committed zero flag
- c_flag  output  1  committed carry flag (borrow for sub ops)
- v_flag  output  1  committed signed-overflow flag
- cin_o  output  1  carry returned to operand-extension stage; equals c_flag
- busy  output  1  any pipeline stage valid

Behaviour:
- Reset: async, active-high.
  - Clears both stage valids, result, z_flag, c_flag, v_flag.
  - out_valid=0, busy=0, cin_o=0.
  - Ops in flight when reset asserts are discarded with no flag commit.
- Stage 1 registers opa, opb, c_in, sub=s[1], we=flag_we on an input handshake (in_valid & in_ready).
- Stage 2 computes and registers:
  - sum = opa + opb + c_in, W+1 bits, zero-extended.
  - r = sum[W-1:0].
  - co = sum[W] ^ sub, so a sub op reports borrow = ~carry-out.
  - z = (r==0).
  - v = (opa[W-1]==opb[W-1]) & (r[W-1]!=opa[W-1]), evaluated on the adjusted operands.
- Latency: an op accepted at edge N presents out_valid=1 after edge N+1, i.e. valid in cycle N+2, with no backpressure. Throughput is 1 op/cycle.
- Ready chain:
  - s2_ready = ~v2 | out_ready
  - s1_ready = ~v1 | s2_ready
  - Stage 1 advances into stage 2 when v1 & s2_ready.
- result and out_valid come from stage 2.
  - result holds stable while out_valid & ~out_ready.
  - result keeps its last value when out_valid=0.
- Flag commit:
  - On the output handshake, if stage-2 we=1, load z_flag, c_flag, v_flag; the new values are visible the next cycle.
  - Ops with we=0 never change flags.
- Carry hazard:
  - An op using cin (s==01 or s==11) while v1&we1 or v2&we2 is true forces in_ready=0.
  - in_ready = s1_ready & ~hazard. in_ready depends combinationally on s.
  - Ops with s==00 or s==10 never see the hazard.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle is permitted; stage 2 reloads from stage 1 on the same edge.
  - Hazard clears in the cycle after the last flag-writing op completes its output handshake.
- busy = v1 | v2.

Test Plan:
- Add overflow: s=00, opa=0x7F, opb=0x01, c_in=0, we=1, accepted at edge N -> out_valid in cycle N+2, result=0x80; after handshake Z=0, C=0, V=1.
- Sub equal: s=10, opa=0x05, opb=0xFA, c_in=1 -> result=0x00, Z=1, C(borrow)=0, V=0.
- Sub with borrow: s=10, opa=0x03, opb=0xFA, c_in=1 -> result=0xFE, C=1, Z=0.
- Carry hazard:
  - Accept s=00 0xFF+0x01 with we=1, then present s=01 the next cycle.
  - Required: in_ready=0 until the first op's output handshake, then cin_o=1.
  - The second op is then fed opa=0x00, opb=0x00, c_in=1 and returns result=0x01.
- Backpressure:
  - Stream 3 ops (values 0x10+0x01, 0x20+0x02, 0x30+0x03) with out_ready=0 for 4 cycles.
  - Required: result holds 0x11, in_ready=0 once both stages are full, then outputs 0x11, 0x22, 0x33 in order with no loss.
  - we=0 ops leave the flags unchanged.
- Reset mid-operation: assert rst with 2 ops in flight -> out_valid, busy and all flags 0 immediately; nothing emitted after rst deasserts.
